// File: rtl/ac97_pkg.sv
// ac97_pkg: shared constants for the AC'97 link engine.
//   Frame geometry (256 bits, 16-bit tag slot followed by twelve 20-bit slots,
//   MSB first), tag bit positions and the link FSM state type.
//   Ports: none (package).
package ac97_pkg;

    localparam int FRAME_LEN   = 256;
    localparam int CNT_W       = $clog2(FRAME_LEN);
    localparam int LAST_BIT    = FRAME_LEN - 1;
    localparam int SAMPLE_W    = 20;
    localparam int TAG_W       = 16;
    localparam int SLOT0_START = 0;

    // Tag bit indices (same meaning in both directions)
    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } link_state_t;

    // First frame bit of data slot k (1..12)
    function automatic logic [CNT_W-1:0] slot_start(input int k);
        return CNT_W'(TAG_W + SAMPLE_W * (k - 1));
    endfunction

endpackage

// File: rtl/ac97_slot_shifter.sv
// ac97_slot_shifter: 20-bit parallel-load, serial-out (MSB first) shift register.
//   clock    in   codec bit clock
//   reset_n  in   asynchronous active-low reset (register clears to 0)
//   load     in   load data this edge (wins over shift)
//   shift    in   shift left by one, zero fill
//   data     in   parallel load word
//   bit_out  out  current MSB, i.e. the bit presented on the serial line
module ac97_slot_shifter
    import ac97_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic                shift,
    input  logic [SAMPLE_W-1:0] data,
    output logic                bit_out
);

    logic [SAMPLE_W-1:0] sr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[SAMPLE_W-2:0], 1'b0};
        end
    end

    assign bit_out = sr[SAMPLE_W-1];

endmodule

// File: rtl/ac97_link.sv
// ac97_link: AC'97 controller link engine, clocked by the codec BIT_CLK.
//   clock, reset_n            bit clock, async active-low reset
//   sync, sdata_out           frame sync and serial data to codec
//   sdata_in                  serial data from codec
//   left_out, right_out       PCM to send (slots 3/4), latched at frame start
//   ready                     one pulse per frame: left_in/right_in fresh, next samples wanted
//   left_in, right_in         received PCM (slots 3/4)
//   cmd_valid/rw/addr/data    register command request; cmd_ready pulses on acceptance
//   status_valid/addr/data    register read-back from the codec
//
// state   | meaning
// STARTUP | sync/sdata_out held low for STARTUP_CYCLES clocks after reset
// RUN     | frames running continuously until reset
module ac97_link
    import ac97_pkg::*;
#(
    parameter int STARTUP_CYCLES = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                sync,
    output logic                sdata_out,
    input  logic                sdata_in,
    input  logic [SAMPLE_W-1:0] left_out,
    input  logic [SAMPLE_W-1:0] right_out,
    output logic                ready,
    output logic [SAMPLE_W-1:0] left_in,
    output logic [SAMPLE_W-1:0] right_in,
    input  logic                cmd_valid,
    input  logic                cmd_rw,
    input  logic [6:0]          cmd_addr,
    input  logic [15:0]         cmd_data,
    output logic                cmd_ready,
    output logic                status_valid,
    output logic [6:0]          status_addr,
    output logic [15:0]         status_data
);

    localparam int SU_W = $clog2(STARTUP_CYCLES + 1);

    link_state_t                 state;
    logic [SU_W-1:0]             startup_cnt;
    logic [CNT_W-1:0]            bit_cnt;
    logic [CNT_W-1:0]            next_cnt;
    logic                        run;
    logic                        frame_start;

    logic                        cmd_taken;
    logic                        cmd_rw_q;
    logic [6:0]                  cmd_addr_q;
    logic [15:0]                 cmd_data_q;
    logic [SAMPLE_W-1:0]         left_q;
    logic [SAMPLE_W-1:0]         right_q;

    logic [2*SAMPLE_W-2:0]       rx_sr;
    logic [2*SAMPLE_W-1:0]       rx_next;
    logic [TAG_READY:TAG_SLOT4]  rx_tag;
    logic [6:0]                  rx_addr;
    logic [15:0]                 rx_data;

    logic                        tx_load;
    logic [SAMPLE_W-1:0]         tx_word;

    assign run         = (state == ST_RUN);
    assign next_cnt    = bit_cnt + 1'b1;
    assign frame_start = run && (bit_cnt == CNT_W'(LAST_BIT));
    // Window of the last 40 received bits including the one sampled this edge
    assign rx_next     = {rx_sr, sdata_in};

    // The shifter output is the registered sdata_out, so each slot is loaded on
    // the edge that moves bit_cnt onto the slot's first bit. The tag is loaded
    // on the frame-start edge itself, hence it uses cmd_valid directly.
    always_comb begin
        tx_load = 1'b0;
        tx_word = '0;
        if (run) begin
            if (next_cnt == CNT_W'(SLOT0_START)) begin
                tx_load = 1'b1;
                tx_word = {1'b1, cmd_valid, cmd_valid, 2'b11, 11'b0, 4'b0};
            end else if (next_cnt == slot_start(1)) begin
                tx_load = 1'b1;
                tx_word = cmd_taken ? {cmd_rw_q, cmd_addr_q, 12'b0} : '0;
            end else if (next_cnt == slot_start(2)) begin
                tx_load = 1'b1;
                tx_word = (cmd_taken && !cmd_rw_q) ? {cmd_data_q, 4'b0} : '0;
            end else if (next_cnt == slot_start(3)) begin
                tx_load = 1'b1;
                tx_word = left_q;
            end else if (next_cnt == slot_start(4)) begin
                tx_load = 1'b1;
                tx_word = right_q;
            end else if (next_cnt == slot_start(5)) begin
                // zero load; zero fill keeps slots 5..12 silent
                tx_load = 1'b1;
            end
        end
    end

    ac97_slot_shifter u_tx (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tx_load),
        .shift   (run),
        .data    (tx_word),
        .bit_out (sdata_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_STARTUP;
            startup_cnt  <= '0;
            bit_cnt      <= '0;
            sync         <= 1'b0;
            ready        <= 1'b0;
            left_in      <= '0;
            right_in     <= '0;
            cmd_ready    <= 1'b0;
            status_valid <= 1'b0;
            status_addr  <= '0;
            status_data  <= '0;
            cmd_taken    <= 1'b0;
            cmd_rw_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            left_q       <= '0;
            right_q      <= '0;
            rx_sr        <= '0;
            rx_tag       <= '0;
            rx_addr      <= '0;
            rx_data      <= '0;
        end else begin
            ready        <= 1'b0;
            cmd_ready    <= 1'b0;
            status_valid <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (startup_cnt == SU_W'(STARTUP_CYCLES - 1)) begin
                        state   <= ST_RUN;
                        bit_cnt <= CNT_W'(LAST_BIT);
                        sync    <= 1'b1;
                    end else begin
                        startup_cnt <= startup_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    bit_cnt <= next_cnt;
                    // high for bit 255 and tag bits 0..14: leads the tag by one clock
                    sync    <= (next_cnt == CNT_W'(LAST_BIT)) ||
                               (next_cnt <= CNT_W'(TAG_W - 2));
                    rx_sr   <= rx_next[2*SAMPLE_W-2:0];

                    if (frame_start) begin
                        left_q    <= left_out;
                        right_q   <= right_out;
                        cmd_taken <= cmd_valid;
                        cmd_ready <= cmd_valid;
                        if (cmd_valid) begin
                            cmd_rw_q   <= cmd_rw;
                            cmd_addr_q <= cmd_addr;
                            cmd_data_q <= cmd_data;
                        end
                    end

                    // whole tag just received: frame bit 0 (tag bit 15) sits at [15]
                    if (next_cnt == slot_start(1)) begin
                        rx_tag <= rx_next[TAG_READY:TAG_SLOT4];
                    end

                    // slots 1 and 2 fill the window: slot1 in [39:20], slot2 in [19:0]
                    if (next_cnt == slot_start(3)) begin
                        rx_addr <= rx_next[38:32];
                        rx_data <= rx_next[19:4];
                    end

                    // last slot-4 bit sampled this edge
                    if (next_cnt == slot_start(5)) begin
                        ready <= 1'b1;
                        if (rx_tag[TAG_SLOT3]) begin
                            left_in <= rx_next[2*SAMPLE_W-1:SAMPLE_W];
                        end
                        if (rx_tag[TAG_SLOT4]) begin
                            right_in <= rx_next[SAMPLE_W-1:0];
                        end
                        if (rx_tag[TAG_READY] && rx_tag[TAG_SLOT1] && rx_tag[TAG_SLOT2]) begin
                            status_valid <= 1'b1;
                            status_addr  <= rx_addr;
                            status_data  <= rx_data;
                        end
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_ac97_link.sv
`timescale 1ns/1ps
module tb_ac97_link;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync, sdata_out;
    logic        sdata_in = 1'b0;
    logic [19:0] left_out = '0, right_out = '0;
    logic        ready;
    logic [19:0] left_in, right_in;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready, status_valid;
    logic [6:0]  status_addr;
    logic [15:0] status_data;

    int checks = 0;
    int errors = 0;

    // model of the last PCM the codec delivered with a valid tag
    logic [19:0] m_left = '0, m_right = '0;

    ac97_link dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sync         (sync),
        .sdata_out    (sdata_out),
        .sdata_in     (sdata_in),
        .left_out     (left_out),
        .right_out    (right_out),
        .ready        (ready),
        .left_in      (left_in),
        .right_in     (right_in),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .status_valid (status_valid),
        .status_addr  (status_addr),
        .status_data  (status_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called with reset_n low, at a negedge. Releases reset and expects 256
    // samples of quiet link, then sync rising (bit_cnt = 255).
    task automatic startup_check(input string name);
        logic [255:0] s_sync, s_dout, s_rdy;
        reset_n = 1'b1;
        s_sync = '0; s_dout = '0; s_rdy = '0;
        s_sync[0] = sync; s_dout[0] = sdata_out; s_rdy[0] = ready;
        for (int k = 1; k < 256; k++) begin
            @(negedge clock);
            s_sync[k] = sync; s_dout[k] = sdata_out; s_rdy[k] = ready;
        end
        chk({name, "_sync_low"}, s_sync, '0);
        chk({name, "_sdata_low"}, s_dout, '0);
        chk({name, "_ready_low"}, s_rdy, '0);
        @(negedge clock);
        chk({name, "_sync_rise"}, sync, 1'b1);
    endtask

    // Runs one frame starting from the bit_cnt=255 period. Builds the expected
    // outgoing frame and the codec's incoming frame as plain bit vectors
    // (index n = frame bit n) and checks every pin over the frame.
    task automatic do_frame(input string name,
                            input logic [19:0] l, input logic [19:0] r,
                            input logic cv, input logic rw,
                            input logic [6:0] addr, input logic [15:0] data,
                            input logic keep, input logic glitch,
                            input logic [15:0] in_tag, input logic [19:0] in_s1,
                            input logic [19:0] in_s2, input logic [19:0] in_l,
                            input logic [19:0] in_r, input int abort_at);
        logic [0:255] in_f, exp_f, got_f;
        logic [255:0] got_sync, got_rdy, got_crdy, got_sv;
        logic [255:0] exp_sync, exp_rdy, exp_crdy, exp_sv;
        logic [15:0]  tag_o;
        logic [19:0]  s1_o, s2_o, exp_left, exp_right;
        logic         st_ok;

        left_out  = l;
        right_out = r;
        cmd_valid = cv;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        sdata_in  = 1'b0;

        tag_o = 16'h9800 | (cv ? 16'h6000 : 16'h0000);
        s1_o  = cv ? {rw, addr, 12'h000} : 20'h0;
        s2_o  = (cv && !rw) ? {data, 4'h0} : 20'h0;
        exp_f = {tag_o, s1_o, s2_o, l, r, 160'b0};
        in_f  = {in_tag, in_s1, in_s2, in_l, in_r, 160'b0};

        st_ok     = in_tag[15] & in_tag[14] & in_tag[13];
        exp_left  = in_tag[12] ? in_l : m_left;
        exp_right = in_tag[11] ? in_r : m_right;

        exp_sync = '0; exp_sync[14:0] = '1; exp_sync[255] = 1'b1;
        exp_rdy  = '0; exp_rdy[96] = 1'b1;
        exp_crdy = '0; exp_crdy[0] = cv;
        exp_sv   = '0; exp_sv[96] = st_ok;
        got_f = '0; got_sync = '0; got_rdy = '0; got_crdy = '0; got_sv = '0;

        for (int n = 0; n < 256; n++) begin
            @(negedge clock);
            sdata_in    = in_f[n];
            got_f[n]    = sdata_out;
            got_sync[n] = sync;
            got_rdy[n]  = ready;
            got_crdy[n] = cmd_ready;
            got_sv[n]   = status_valid;
            if (n == 0 && !keep) cmd_valid = 1'b0;
            if (glitch && n == 100) cmd_valid = 1'b1;
            if (glitch && n == 200) cmd_valid = 1'b0;
            if (n == 96) begin
                chk({name, "_left_in"}, left_in, exp_left);
                chk({name, "_right_in"}, right_in, exp_right);
                if (st_ok) begin
                    chk({name, "_status_addr"}, status_addr, in_s1[18:12]);
                    chk({name, "_status_data"}, status_data, in_s2[19:4]);
                end
            end
            if (n == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk({name, "_abort_outputs"},
                    {sync, sdata_out, ready, cmd_ready, status_valid,
                     left_in, right_in, status_addr, status_data}, '0);
                m_left  = '0;
                m_right = '0;
                cmd_valid = 1'b0;
                return;
            end
        end

        chk({name, "_tx_frame"}, got_f, exp_f);
        chk({name, "_sync"}, got_sync, exp_sync);
        chk({name, "_ready"}, got_rdy, exp_rdy);
        chk({name, "_cmd_ready"}, got_crdy, exp_crdy);
        chk({name, "_status_valid"}, got_sv, exp_sv);
        m_left  = exp_left;
        m_right = exp_right;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_sync_sdata", {sync, sdata_out}, '0);
        chk("reset_pulses", {ready, cmd_ready, status_valid}, '0);
        chk("reset_pcm", {left_in, right_in}, '0);
        chk("reset_status", {status_addr, status_data}, '0);

        startup_check("startup");

        // idle frame, codec tag with only codec-ready: nothing captured
        do_frame("tag8000", 20'($urandom), 20'($urandom), 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b0, 16'h8000, 20'($urandom), 20'($urandom),
                 20'($urandom), 20'($urandom), -1);

        do_frame("pcm_fixed", 20'hABCDE, 20'h12345, 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b0, 16'h9800, 20'h0, 20'h0,
                 20'($urandom), 20'($urandom), -1);

        // register write out, status read-back in
        do_frame("cmd_write", 20'($urandom), 20'($urandom), 1'b1, 1'b0, 7'h02, 16'h8000,
                 1'b0, 1'b0, 16'hF800, {1'b1, 7'h26, 12'h000}, {16'h000F, 4'h0},
                 20'h54321, 20'h0F0F0, -1);

        do_frame("after_cmd", 20'($urandom), 20'($urandom), 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b0, 16'h9000, 20'($urandom), 20'($urandom),
                 20'($urandom), 20'($urandom), -1);

        // cmd_valid held across two frames: one accept in each
        do_frame("cmd_held_a", 20'($urandom), 20'($urandom), 1'b1, 1'b1, 7'($urandom),
                 16'($urandom), 1'b1, 1'b0, 16'($urandom), 20'($urandom),
                 20'($urandom), 20'($urandom), 20'($urandom), -1);
        do_frame("cmd_held_b", 20'($urandom), 20'($urandom), 1'b1, 1'b0, 7'($urandom),
                 16'($urandom), 1'b0, 1'b0, 16'hE800, 20'($urandom),
                 20'($urandom), 20'($urandom), 20'($urandom), -1);

        // cmd_valid pulsed mid-frame and dropped before the next frame start
        do_frame("cmd_glitch", 20'($urandom), 20'($urandom), 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b1, 16'($urandom), 20'($urandom), 20'($urandom),
                 20'($urandom), 20'($urandom), -1);
        do_frame("post_glitch", 20'($urandom), 20'($urandom), 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b0, 16'($urandom), 20'($urandom), 20'($urandom),
                 20'($urandom), 20'($urandom), -1);

        for (int i = 0; i < 4; i++) begin
            do_frame($sformatf("rand%0d", i), 20'($urandom), 20'($urandom),
                     1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom),
                     1'b0, 1'b0, 16'($urandom), 20'($urandom), 20'($urandom),
                     20'($urandom), 20'($urandom), -1);
        end

        // mid-frame reset at bit_cnt=100, then a full restart
        do_frame("abort", 20'($urandom), 20'($urandom), 1'b0, 1'b0, 7'h0, 16'h0,
                 1'b0, 1'b0, 16'hF800, {1'b0, 7'h11, 12'h000}, {16'hBEEF, 4'h0},
                 20'($urandom), 20'($urandom), 100);
        repeat (2) @(negedge clock);
        chk("abort_held_low", {sync, sdata_out, ready, left_in}, '0);
        startup_check("restart");
        do_frame("after_restart", 20'($urandom), 20'($urandom), 1'b1, 1'b1, 7'h26, 16'h0,
                 1'b0, 1'b0, 16'hF800, {1'b0, 7'h7C, 12'h000}, {16'h1234, 4'h0},
                 20'($urandom), 20'($urandom), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
